vector_addsub_pipe: RTL

//  N-lane signed fixed-point vector add/subtract with a per-beat op select and a per-lane mask.
//  LAT-deep elastic pipeline with valid/ready backpressure on both sides; tlast-style 'last' tag carried alongside data.

---
 rtl/vector_addsub_pipe.sv | 121 ++++++++++++
 1 files changed

// File: rtl/vector_addsub_pipe.sv
// N-lane signed vector add/subtract behind a LAT-deep elastic valid/ready pipeline with overflow flags.
// Build option: define VECTOR_ADDSUB_SAT_EN to clamp overflowing lanes instead of wrapping.
module vector_addsub_pipe #(
  parameter int bitwidth = 16,
  parameter int N        = 8,
  parameter int LAT      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N*bitwidth-1:0] in0,
  input  logic [N*bitwidth-1:0] in1,
  input  logic                  in_op,
  input  logic [N-1:0]          in_mask,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [N*bitwidth-1:0] out,
  output logic [N-1:0]          out_ovf,
  output logic                  out_valid,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int W = N * bitwidth;

  logic [W-1:0]   calc_res;
  logic [N-1:0]   calc_ovf;

  logic [W-1:0]   data_reg [LAT];
  logic [N-1:0]   ovf_reg  [LAT];
  logic [LAT-1:0] v_reg;
  logic [LAT-1:0] last_reg;
  logic [LAT-1:0] adv;
  logic           sticky_reg;

  // Per-lane arithmetic, one bit wider than the lane so the true result is always representable.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic signed [bitwidth:0] a_ext;
      logic signed [bitwidth:0] b_ext;
      logic signed [bitwidth:0] sum_ext;
      logic                     ovf_raw;
      logic [bitwidth-1:0]      lane_val;

      assign a_ext   = {in0[gi*bitwidth+bitwidth-1], in0[gi*bitwidth +: bitwidth]};
      assign b_ext   = {in1[gi*bitwidth+bitwidth-1], in1[gi*bitwidth +: bitwidth]};
      assign sum_ext = in_op ? (a_ext - b_ext) : (a_ext + b_ext);
      assign ovf_raw = sum_ext[bitwidth] ^ sum_ext[bitwidth-1];

`ifdef VECTOR_ADDSUB_SAT_EN
      // The extended sign bit tells which rail the true result crossed.
      assign lane_val = !ovf_raw ? sum_ext[bitwidth-1:0]
                      : sum_ext[bitwidth] ? {1'b1, {(bitwidth-1){1'b0}}}
                      : {1'b0, {(bitwidth-1){1'b1}}};
`else
      assign lane_val = sum_ext[bitwidth-1:0];
`endif

      assign calc_res[gi*bitwidth +: bitwidth] = in_mask[gi] ? lane_val : in0[gi*bitwidth +: bitwidth];
      assign calc_ovf[gi] = in_mask[gi] & ovf_raw;
    end
  endgenerate

  // A stage may load when it is empty or its contents move on; bubbles therefore collapse.
  always_comb begin
    adv = '0;
    adv[LAT-1] = out_ready | ~v_reg[LAT-1];
    for (int k = LAT - 2; k >= 0; k--) begin
      adv[k] = ~v_reg[k] | adv[k+1];
    end
  end

  assign in_ready = adv[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      v_reg      <= '0;
      last_reg   <= '0;
      sticky_reg <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        data_reg[k] <= '0;
        ovf_reg[k]  <= '0;
      end
    end else begin
      if (adv[0]) begin
        v_reg[0] <= in_valid;
        if (in_valid) begin
          data_reg[0] <= calc_res;
          ovf_reg[0]  <= calc_ovf;
          last_reg[0] <= in_last;
        end
      end
      // Payload only moves with a valid beat so the output holds its last value while idle.
      for (int k = 1; k < LAT; k++) begin
        if (adv[k]) begin
          v_reg[k] <= v_reg[k-1];
          if (v_reg[k-1]) begin
            data_reg[k] <= data_reg[k-1];
            ovf_reg[k]  <= ovf_reg[k-1];
            last_reg[k] <= last_reg[k-1];
          end
        end
      end
      if (ovf_clr) begin
        sticky_reg <= 1'b0;
      end else if (v_reg[LAT-1] && out_ready && (|ovf_reg[LAT-1])) begin
        sticky_reg <= 1'b1;
      end
    end
  end

  assign out        = data_reg[LAT-1];
  assign out_ovf    = ovf_reg[LAT-1];
  assign out_valid  = v_reg[LAT-1];
  assign out_last   = last_reg[LAT-1];
  assign ovf_sticky = sticky_reg;

endmodule
